register_pipe_rstn: RTL and testbench
=====================================

# register_pipe_rstn

Parametrised, ready/valid register pipeline: DEPTH cascaded skid-buffer stages carrying WIDTH-bit words with full throughput. Every output, including upstream ready, is driven directly from a flop. It is the handshake-aware successor to the plain reset register and is placed wherever a long or congested path needs retiming without breaking a valid/ready protocol. It also provides a synchronous flush and an occupancy count for debug and drain checks.

## Interface
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 2, number of skid-buffer stages (>=1); total capacity 2*DEPTH words.
- CNT_W, $clog2(2*DEPTH+1), width of the occupancy output (derived, not overridden).
- clk  input  1  single clock; all state updates on rising edge.
- rstn  input  1  asynchronous, active-low reset. Asserting it clears all state immediately. Deassertion is expected to be synchronised to clk externally.
- flush  input  1  synchronous clear of all stored words.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  word available at output.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  WIDTH  output word, from the last stage's main register.
- count  output  CNT_W  number of words currently held, 0..2*DEPTH.

## Operation
- Each stage i holds a main register (m_valid, m_data) and a skid register (s_valid, s_data).
  - Stage ready to its upstream = ~s_valid (registered).
  - Stage output = main register.
  - Stage 0 upstream is in_*; stage DEPTH-1 downstream is out_*; stage i feeds stage i+1.
- Per-stage states:
  - EMPTY (m=0, s=0).
  - HALF (m=1, s=0).
  - FULL (m=1, s=1).
  - s=1 with m=0 is illegal and must never occur.
- Stage transitions per edge, with acc = upstream valid & stage ready and take = m_valid & downstream ready:
  - EMPTY, acc -> HALF (data into main).
  - HALF, acc & take -> HALF (main <= new).
  - HALF, acc & ~take -> FULL (new word into skid).
  - HALF, ~acc & take -> EMPTY.
  - FULL, take -> HALF (main <= skid). No accept is possible because ready=0.
  - All other cases: hold.
- Order is strictly FIFO; no word is duplicated or dropped except by flush or reset.
- flush=1:
  - All m_valid/s_valid clear on the next edge; data registers may hold stale values.
  - in_ready and out_valid are forced low combinationally during the flush cycle, so no handshake completes on either side.
  - Flush overrides any concurrent in_valid/out_ready.
- count:
  - Registered; equals the sum of all m_valid and s_valid bits.
  - Updated on the same edge as the valid bits: +1 on an input handshake, -1 on an output handshake, unchanged when both occur.
  - Goes to 0 after flush.
- Reset values (rstn=0): all valid bits 0, all data registers 0, in_ready=1 (after reset release, with flush=0), out_valid=0, out_data=0, count=0.

## Timing
- Latency:
  - A word accepted in cycle N appears with out_valid=1 in cycle N+DEPTH when every stage is empty and out_ready stays high.
  - DEPTH=1 gives 1 cycle of latency.
- Throughput: one word per cycle sustained with out_ready held high. in_ready never drops in steady streaming.
- Backpressure:
  - With out_ready=0 and in_valid held high, exactly 2*DEPTH words are accepted.
  - in_ready is deasserted in the cycle after the last accept.
  - in_ready never falls in the same cycle as the out_ready change that caused it (registered ready).
- Refill: after out_ready returns high, in_ready reasserts within DEPTH cycles.
- out_data must stay stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all words are lost asynchronously. Outputs reach their reset values without waiting for a clock edge.
- Simultaneous in/out handshake when count=2*DEPTH is impossible because in_ready=0. When count=0, out_valid=0, so there is no bypass path.

## Test plan
- Directed scenarios, with DEPTH=2 and WIDTH=8:
  - Reset, then stream 0x01..0x10 with out_ready=1 -> first out_valid 2 cycles after first accept; out_data 0x01..0x10 in order, one per cycle; count settles at 2.
  - out_ready=0, in_valid=1 with words 0xA0.. -> exactly 4 accepts (0xA0..0xA3); in_ready low from the next cycle; count=4; out_data held at 0xA0.
  - From the full state, out_ready=1 for a single cycle -> one word 0xA0 leaves; count=3; in_ready high within 2 cycles; order stays 0xA1,0xA2,0xA3 then new words.
  - Random in_valid/out_ready at 50% for 10k cycles -> scoreboard matches; count always equals accepts minus releases; the s=1/m=0 state is never observed.
  - flush while count=3 and in_valid=out_ready=1 -> no handshake on either side that cycle; next cycle count=0, out_valid=0, in_ready=1.
  - rstn pulsed low asynchronously between edges with count=4 -> out_valid, count and out_data go to 0 immediately; after release, the first word streams with DEPTH-cycle latency.

Source files
------------

// File: rtl/register_pipe_rstn.sv
// ---------------------------------------------------------------------------
// register_pipe_rstn
//
// Ready/valid register pipeline built from DEPTH cascaded skid-buffer stages.
// Each stage has a main register, which drives its output, and a skid
// register that catches the word arriving in the same cycle its downstream
// stalls. Stage ready is the inverse of the registered skid-valid, so the
// handshake path is cut at every stage. The pipeline sustains one word per
// cycle and holds up to 2*DEPTH words.
//
// Parameters:
//   WIDTH  data word width in bits
//   DEPTH  number of skid-buffer stages (capacity 2*DEPTH words)
//   CNT_W  occupancy width, derived from DEPTH
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset, clears all state
//   flush      synchronous clear of every stored word
//   in_valid   upstream word valid
//   in_ready   pipeline can accept a word this cycle
//   in_data    upstream word
//   out_valid  word available at the output
//   out_ready  downstream accepts the word this cycle
//   out_data   output word (last stage main register)
//   count      number of words currently held, 0..2*DEPTH
// ---------------------------------------------------------------------------
module register_pipe_rstn #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(2 * DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  // Bit 0 is the main-valid and bit 1 the skid-valid, so the unused
  // encoding 2'b10 is exactly the forbidden "skid without main" condition.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_e;

  stage_state_e state_q [DEPTH];
  stage_state_e state_d [DEPTH];

  logic [DEPTH-1:0][WIDTH-1:0] m_data_q, m_data_d;
  logic [DEPTH-1:0][WIDTH-1:0] s_data_q, s_data_d;
  logic [DEPTH-1:0][WIDTH-1:0] up_data;

  logic [DEPTH-1:0] m_valid, s_valid;
  logic [DEPTH-1:0] up_valid, dn_ready;
  logic [DEPTH-1:0] acc, take;

  logic [CNT_W-1:0] count_q, count_d;
  logic             in_hs, out_hs;

  // Decode each stage state into its main/skid valid flags.
  always_comb begin
    m_valid = '0;
    s_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = (state_q[i] != ST_EMPTY);
      s_valid[i] = (state_q[i] == ST_FULL);
    end
  end

  // Chain the stages: stage 0 listens to the input port, every later stage
  // listens to the main register of the stage before it. Downstream ready of
  // a stage is the registered ready (no skid word) of the next stage, and the
  // last stage sees out_ready directly.
  always_comb begin
    up_valid    = '0;
    up_data     = '0;
    dn_ready    = '0;
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_valid[i] = m_valid[i-1];
      up_data[i]  = m_data_q[i-1];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      dn_ready[i] = ~s_valid[i+1];
    end
    dn_ready[DEPTH-1] = out_ready;
  end

  // Per-stage next state. A HALF stage that accepts while its main word is
  // also leaving simply replaces the main word; only an accept without a
  // take spills into the skid register. A FULL stage cannot accept (its
  // ready is low), so the only move out of FULL is promoting skid to main.
  // Flush empties every stage and leaves the data registers stale.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    acc      = '0;
    take     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      acc[i]  = up_valid[i] & ~s_valid[i];
      take[i] = m_valid[i] & dn_ready[i];
      case (state_q[i])
        ST_EMPTY: begin
          if (acc[i]) begin
            state_d[i]  = ST_HALF;
            m_data_d[i] = up_data[i];
          end
        end
        ST_HALF: begin
          if (acc[i] && take[i]) begin
            m_data_d[i] = up_data[i];
          end else if (acc[i]) begin
            state_d[i]  = ST_FULL;
            s_data_d[i] = up_data[i];
          end else if (take[i]) begin
            state_d[i] = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (take[i]) begin
            state_d[i]  = ST_HALF;
            m_data_d[i] = s_data_q[i];
          end
        end
        default: state_d[i] = ST_EMPTY;
      endcase
      if (flush) begin
        state_d[i] = ST_EMPTY;
      end
    end
  end

  // Port handshakes. Flush masks both sides so no word is exchanged in the
  // flush cycle; apart from that gate, both signals come straight from flops.
  assign in_ready  = ~s_valid[0] & ~flush;
  assign out_valid = m_valid[DEPTH-1] & ~flush;
  assign out_data  = m_data_q[DEPTH-1];
  assign count     = count_q;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  // Occupancy tracks the port handshakes rather than summing the valid
  // bits, which keeps it a simple up/down counter.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_hs && !out_hs) begin
      count_d = count_q + CNT_W'(1);
    end else if (!in_hs && out_hs) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // All state registers; reset clears valids, data and count at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_EMPTY;
      end
      m_data_q <= '0;
      s_data_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_register_pipe_rstn.sv
// ---------------------------------------------------------------------------
// tb_register_pipe_rstn
//
// Directed bench for register_pipe_rstn with DEPTH=2, WIDTH=8. Each task
// drives one scenario and compares outputs against hand-derived values.
// Inputs change 1 ns after the rising edge and outputs are sampled 1 ns
// later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_register_pipe_rstn;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(2 * DEPTH + 1);

  logic             clk = 1'b0;
  logic             rstn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  register_pipe_rstn #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Hard time limit so the run always terminates.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to 1 ns after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset values while rstn is low and just after release.
  task automatic test_reset();
    rstn      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset out_valid got %b expected 0", out_valid); end
    n_checks++; if (count !== CNT_W'(0)) begin n_fail++; $display("[TB] FAIL reset count got %0d expected 0", count); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset out_data got %h expected 00", out_data); end
    rstn = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset in_ready got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rel out_valid got %b expected 0", out_valid); end
  endtask

  // Stream 0x01..0x10 with out_ready high: two-cycle latency, one word per
  // cycle, occupancy settles at 2 while streaming.
  task automatic test_stream();
    int acc_n, rel_n;
    next_cycle();
    for (int c = 0; c < 20; c++) begin
      out_ready = 1'b1;
      in_valid  = (c < 16);
      in_data   = 8'(c + 1);
      #1;
      acc_n = (c < 16) ? c : 16;
      rel_n = (c < 2) ? 0 : ((c - 2 < 16) ? c - 2 : 16);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stream in_ready c=%0d got %b expected 1", c, in_ready); end
      n_checks++; if (out_valid !== (c >= 2 && c < 18)) begin n_fail++; $display("[TB] FAIL stream out_valid c=%0d got %b expected %b", c, out_valid, (c >= 2 && c < 18)); end
      if (c >= 2 && c < 18) begin
        n_checks++; if (out_data !== 8'(c - 1)) begin n_fail++; $display("[TB] FAIL stream out_data c=%0d got %h expected %h", c, out_data, 8'(c - 1)); end
      end
      n_checks++; if (count !== CNT_W'(acc_n - rel_n)) begin n_fail++; $display("[TB] FAIL stream count c=%0d got %0d expected %0d", c, count, acc_n - rel_n); end
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  // out_ready low, in_valid high: exactly four accepts (A0..A3), in_ready
  // low from the cycle after the fourth accept, out_data held at A0.
  task automatic test_backpressure();
    for (int c = 0; c < 8; c++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hA0 + 8'((c < 4) ? c : 4);
      #1;
      n_checks++; if (in_ready !== (c < 4)) begin n_fail++; $display("[TB] FAIL bp in_ready c=%0d got %b expected %b", c, in_ready, (c < 4)); end
      n_checks++; if (count !== CNT_W'((c < 4) ? c : 4)) begin n_fail++; $display("[TB] FAIL bp count c=%0d got %0d expected %0d", c, count, (c < 4) ? c : 4); end
      n_checks++; if (out_valid !== (c >= 2)) begin n_fail++; $display("[TB] FAIL bp out_valid c=%0d got %b expected %b", c, out_valid, (c >= 2)); end
      if (c >= 2) begin
        n_checks++; if (out_data !== 8'hA0) begin n_fail++; $display("[TB] FAIL bp out_data c=%0d got %h expected a0", c, out_data); end
      end
      next_cycle();
    end
  endtask

  // From full: a single out_ready pulse releases A0, in_ready returns two
  // cycles later and A4 is accepted; the drain then yields A1..A4 in order.
  task automatic test_release();
    logic       or_tab [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       iv_tab [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ir_tab [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int         ct_tab [8] = '{4, 3, 3, 4, 3, 2, 1, 0};
    logic       ov_tab [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] od_tab [8] = '{8'hA0, 8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00};
    for (int r = 0; r < 8; r++) begin
      out_ready = or_tab[r];
      in_valid  = iv_tab[r];
      in_data   = 8'hA4;
      #1;
      n_checks++; if (in_ready !== ir_tab[r]) begin n_fail++; $display("[TB] FAIL release in_ready r=%0d got %b expected %b", r, in_ready, ir_tab[r]); end
      n_checks++; if (count !== CNT_W'(ct_tab[r])) begin n_fail++; $display("[TB] FAIL release count r=%0d got %0d expected %0d", r, count, ct_tab[r]); end
      n_checks++; if (out_valid !== ov_tab[r]) begin n_fail++; $display("[TB] FAIL release out_valid r=%0d got %b expected %b", r, out_valid, ov_tab[r]); end
      if (ov_tab[r]) begin
        n_checks++; if (out_data !== od_tab[r]) begin n_fail++; $display("[TB] FAIL release out_data r=%0d got %h expected %h", r, out_data, od_tab[r]); end
      end
      next_cycle();
    end
  endtask

  // Flush with three words held and both handshakes requested: nothing is
  // exchanged that cycle, the pipe is empty next cycle, and a fresh word C0
  // then streams with two-cycle latency (no stale word reappears).
  task automatic test_flush();
    logic       fl_tab [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       iv_tab [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] id_tab [9] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h00, 8'hC0, 8'h00, 8'h00, 8'h00};
    logic       or_tab [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       ir_tab [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int         ct_tab [9] = '{0, 1, 2, 3, 0, 0, 1, 1, 0};
    logic       ov_tab [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] od_tab [9] = '{8'h00, 8'h00, 8'hB0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'h00};
    for (int f = 0; f < 9; f++) begin
      flush     = fl_tab[f];
      in_valid  = iv_tab[f];
      in_data   = id_tab[f];
      out_ready = or_tab[f];
      #1;
      n_checks++; if (in_ready !== ir_tab[f]) begin n_fail++; $display("[TB] FAIL flush in_ready f=%0d got %b expected %b", f, in_ready, ir_tab[f]); end
      n_checks++; if (count !== CNT_W'(ct_tab[f])) begin n_fail++; $display("[TB] FAIL flush count f=%0d got %0d expected %0d", f, count, ct_tab[f]); end
      n_checks++; if (out_valid !== ov_tab[f]) begin n_fail++; $display("[TB] FAIL flush out_valid f=%0d got %b expected %b", f, out_valid, ov_tab[f]); end
      if (ov_tab[f]) begin
        n_checks++; if (out_data !== od_tab[f]) begin n_fail++; $display("[TB] FAIL flush out_data f=%0d got %h expected %h", f, out_data, od_tab[f]); end
      end
      next_cycle();
    end
    flush = 1'b0;
  endtask

  // Fill to four words, pull rstn low between edges and check the outputs
  // clear without a clock edge; after release a word streams with DEPTH
  // cycles of latency.
  task automatic test_async_reset();
    for (int a = 0; a < 4; a++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hD0 + 8'(a);
      #1;
      n_checks++; if (count !== CNT_W'(a)) begin n_fail++; $display("[TB] FAIL arst fill count a=%0d got %0d expected %0d", a, count, a); end
      next_cycle();
    end
    in_valid = 1'b0;
    #1;
    n_checks++; if (count !== CNT_W'(4)) begin n_fail++; $display("[TB] FAIL arst full count got %0d expected 4", count); end
    n_checks++; if (out_data !== 8'hD0) begin n_fail++; $display("[TB] FAIL arst full out_data got %h expected d0", out_data); end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL arst out_valid got %b expected 0", out_valid); end
    n_checks++; if (count !== CNT_W'(0)) begin n_fail++; $display("[TB] FAIL arst count got %0d expected 0", count); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL arst out_data got %h expected 00", out_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL arst in_ready got %b expected 1", in_ready); end
    next_cycle();
    rstn = 1'b1;
    next_cycle();
    for (int e = 0; e < 4; e++) begin
      out_ready = 1'b1;
      in_valid  = (e == 0);
      in_data   = (e == 0) ? 8'hE5 : 8'h00;
      #1;
      n_checks++; if (out_valid !== (e == 2)) begin n_fail++; $display("[TB] FAIL arst_stream out_valid e=%0d got %b expected %b", e, out_valid, (e == 2)); end
      if (e == 2) begin
        n_checks++; if (out_data !== 8'hE5) begin n_fail++; $display("[TB] FAIL arst_stream out_data got %h expected e5", out_data); end
      end
      n_checks++; if (count !== CNT_W'((e == 1 || e == 2) ? 1 : 0)) begin n_fail++; $display("[TB] FAIL arst_stream count e=%0d got %0d", e, count); end
      next_cycle();
    end
  endtask

  // Random valid/ready traffic against a FIFO scoreboard: delivered words
  // match accepted words in order and count equals words in flight.
  task automatic test_random();
    logic [7:0] sb [$];
    logic       in_hs, out_hs;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      #1;
      n_checks++; if (count !== CNT_W'(sb.size())) begin n_fail++; $display("[TB] FAIL random count c=%0d got %0d expected %0d", c, count, sb.size()); end
      in_hs  = in_valid & in_ready;
      out_hs = out_valid & out_ready;
      if (out_hs) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("[TB] FAIL random out_empty c=%0d got %h expected no word", c, out_data);
        end else begin
          if (out_data !== sb[0]) begin n_fail++; $display("[TB] FAIL random out_data c=%0d got %h expected %h", c, out_data, sb[0]); end
          void'(sb.pop_front());
        end
      end
      if (in_hs) sb.push_back(in_data);
      next_cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_release();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
